ahb_arbiter: RTL and testbench



---
 rtl/ahb_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_ahb_arbiter.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_arbiter.sv
// ---------------------------------------------------------------------------
// ahb_arbiter
//   Round-robin arbiter sharing one AHB address/data bus between MASTER_NUM
//   masters. Grants are registered and one-hot. The arbiter also tracks the
//   address-phase and data-phase owner IDs that steer the bus multiplexers.
//   Grants are frozen in the middle of a fixed-length burst and during a
//   locked sequence.
//
// Ports
//   ahb_clk_in          : bus clock, rising edge
//   ahb_rst_in          : synchronous reset, active-high
//   ahb_busreq_in       : per-master bus request
//   ahb_lock_in         : per-master locked-transfer request
//   ahb_trans_in        : HTRANS of current address owner
//   ahb_burst_in        : HBURST of current address owner
//   ahb_ready_in        : bus HREADY
//   ahb_resp_in         : 1 = ERROR response
//   ahb_grant_out       : registered one-hot grant
//   ahb_master_out      : address-phase owner
//   ahb_master_data_out : data-phase owner
//   ahb_mastlock_out    : current address phase is locked
// ---------------------------------------------------------------------------
module ahb_arbiter #(
  parameter int MASTER_NUM      = 4,
  parameter int MASTER_ID_WIDTH = 2,
  parameter int DEFAULT_MASTER  = 0
) (
  input  logic                       ahb_clk_in,
  input  logic                       ahb_rst_in,
  input  logic [MASTER_NUM-1:0]      ahb_busreq_in,
  input  logic [MASTER_NUM-1:0]      ahb_lock_in,
  input  logic [1:0]                 ahb_trans_in,
  input  logic [2:0]                 ahb_burst_in,
  input  logic                       ahb_ready_in,
  input  logic                       ahb_resp_in,
  output logic [MASTER_NUM-1:0]      ahb_grant_out,
  output logic [MASTER_ID_WIDTH-1:0] ahb_master_out,
  output logic [MASTER_ID_WIDTH-1:0] ahb_master_data_out,
  output logic                       ahb_mastlock_out
);

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_OWN   = 2'd1,
    ARB_BURST = 2'd2,
    ARB_LOCK  = 2'd3
  } arb_state_e;

  localparam logic [1:0] TRANS_IDLE   = 2'd0;
  localparam logic [1:0] TRANS_BUSY   = 2'd1;
  localparam logic [1:0] TRANS_NONSEQ = 2'd2;
  localparam logic [1:0] TRANS_SEQ    = 2'd3;

  localparam logic [MASTER_ID_WIDTH-1:0] DEF_ID    = MASTER_ID_WIDTH'(DEFAULT_MASTER);
  localparam logic [MASTER_NUM-1:0]      DEF_GRANT = MASTER_NUM'(1) << DEFAULT_MASTER;

  // Beats remaining after the current one for a given HBURST.
  function automatic logic [3:0] burst_last(input logic [2:0] burst);
    case (burst)
      3'd2, 3'd3: return 4'd3;
      3'd4, 3'd5: return 4'd7;
      3'd6, 3'd7: return 4'd15;
      default:    return 4'd0;
    endcase
  endfunction

  // Index of the set bit of a one-hot vector.
  function automatic logic [MASTER_ID_WIDTH-1:0] onehot_to_id(input logic [MASTER_NUM-1:0] oh);
    logic [MASTER_ID_WIDTH-1:0] id;
    id = '0;
    for (int i = 0; i < MASTER_NUM; i++) begin
      if (oh[i]) begin
        id = MASTER_ID_WIDTH'(i);
      end else begin
        id = id;
      end
    end
    return id;
  endfunction

  arb_state_e                 state_q, state_d;
  logic [3:0]                 cnt_q, cnt_d;
  logic [MASTER_NUM-1:0]      grant_q, grant_d;
  logic [MASTER_ID_WIDTH-1:0] master_q, master_d;
  logic [MASTER_ID_WIDTH-1:0] master_data_q, master_data_d;
  logic                       mastlock_q, mastlock_d;

  logic [MASTER_ID_WIDTH-1:0] grant_id_s;
  logic [MASTER_ID_WIDTH-1:0] cand_id_s;
  logic                       lock_owner_s;
  logic                       rearb_s;

  assign grant_id_s   = onehot_to_id(grant_q);
  assign lock_owner_s = ahb_lock_in[grant_id_s];

  // Beat counter: next value follows HTRANS on accepted beats; an error
  // response abandons the burst immediately.
  always_comb begin
    cnt_d = cnt_q;
    if (ahb_resp_in && !ahb_ready_in) begin
      cnt_d = 4'd0;
    end else if (ahb_ready_in) begin
      case (ahb_trans_in)
        TRANS_NONSEQ: cnt_d = burst_last(ahb_burst_in);
        TRANS_SEQ:    cnt_d = (cnt_q != 4'd0) ? (cnt_q - 4'd1) : 4'd0;
        TRANS_IDLE:   cnt_d = 4'd0;
        TRANS_BUSY:   cnt_d = cnt_q;
        default:      cnt_d = cnt_q;
      endcase
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Round-robin candidate: rotate from the master after the most recently
  // granted one, so the holder of the grant is considered last.
  always_comb begin : cand_search
    logic found;
    found     = 1'b0;
    cand_id_s = DEF_ID;
    for (int i = 1; i <= MASTER_NUM; i++) begin
      for (int j = 0; j < MASTER_NUM; j++) begin
        if (!found && ahb_busreq_in[j] && (j == ((int'(grant_id_s) + i) % MASTER_NUM))) begin
          cand_id_s = MASTER_ID_WIDTH'(j);
          found     = 1'b1;
        end else begin
          found = found;
        end
      end
    end
  end

  // Re-arbitrate on ready edges outside a fixed burst and outside a lock.
  // A state of ARB_LOCK with lock now low still blocks this edge, giving
  // one unlocked address phase before the grant may move.
  assign rearb_s = ahb_ready_in && (state_q != ARB_LOCK) && !lock_owner_s && (cnt_d <= 4'd1);

  // Next-state, grant and owner handover.
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    master_d      = master_q;
    master_data_d = master_data_q;
    mastlock_d    = mastlock_q;
    if (ahb_ready_in) begin
      if (lock_owner_s) begin
        state_d = ARB_LOCK;
      end else if (cnt_d > 4'd1) begin
        state_d = ARB_BURST;
      end else if (|ahb_busreq_in) begin
        state_d = ARB_OWN;
      end else begin
        state_d = ARB_IDLE;
      end
      master_d      = grant_id_s;
      master_data_d = master_q;
      mastlock_d    = lock_owner_s;
    end else begin
      state_d = state_q;
    end
    if (rearb_s) begin
      grant_d = MASTER_NUM'(1) << cand_id_s;
    end else begin
      grant_d = grant_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge ahb_clk_in) begin
    if (ahb_rst_in) begin
      state_q       <= ARB_IDLE;
      cnt_q         <= 4'd0;
      grant_q       <= DEF_GRANT;
      master_q      <= DEF_ID;
      master_data_q <= DEF_ID;
      mastlock_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      grant_q       <= grant_d;
      master_q      <= master_d;
      master_data_q <= master_data_d;
      mastlock_q    <= mastlock_d;
    end
  end

  assign ahb_grant_out       = grant_q;
  assign ahb_master_out      = master_q;
  assign ahb_master_data_out = master_data_q;
  assign ahb_mastlock_out    = mastlock_q;

endmodule

// File: tb/tb_ahb_arbiter.sv
// Testbench for ahb_arbiter: directed scenarios with fixed expectations plus
// randomized traffic compared against a behavioural model of the arbiter.
module tb_ahb_arbiter;
  localparam int N   = 4;
  localparam int DEF = 0;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] busreq, lock;
  logic [1:0] trans;
  logic [2:0] burst;
  logic       ready, resp;
  logic [3:0] grant;
  logic [1:0] master, data;
  logic       mastlock;
  logic [8:0] obs;

  int n_checks = 0;
  int n_pass   = 0;

  // Behavioural model state
  int m_grant, m_owner, m_data, m_rem;
  bit m_lock, m_in_lock;
  int beats [8] = '{1, 1, 4, 4, 8, 8, 16, 16};

  ahb_arbiter #(.MASTER_NUM(4), .MASTER_ID_WIDTH(2), .DEFAULT_MASTER(0)) dut (
    .ahb_clk_in         (clk),
    .ahb_rst_in         (rst),
    .ahb_busreq_in      (busreq),
    .ahb_lock_in        (lock),
    .ahb_trans_in       (trans),
    .ahb_burst_in       (burst),
    .ahb_ready_in       (ready),
    .ahb_resp_in        (resp),
    .ahb_grant_out      (grant),
    .ahb_master_out     (master),
    .ahb_master_data_out(data),
    .ahb_mastlock_out   (mastlock)
  );

  always #5 clk = ~clk;

  assign obs = {grant, master, data, mastlock};

  // Predict the effect of the coming clock edge from the current inputs.
  task automatic model_edge();
    int nx_rem;
    int order[$];
    int cand;
    bit frozen;
    if (rst) begin
      m_grant = DEF; m_owner = DEF; m_data = DEF; m_lock = 0; m_rem = 0; m_in_lock = 0;
      return;
    end
    nx_rem = m_rem;
    if (resp && !ready) nx_rem = 0;
    else if (ready) begin
      if (trans == 2'd2) nx_rem = beats[burst] - 1;
      else if (trans == 2'd3) nx_rem = (m_rem > 0) ? m_rem - 1 : 0;
      else if (trans == 2'd0) nx_rem = 0;
    end
    if (ready) begin
      frozen = m_in_lock || lock[m_grant] || (nx_rem > 1);
      for (int k = 1; k <= N; k++) order.push_back((m_grant + k) % N);
      cand = DEF;
      foreach (order[k]) if (busreq[order[k]] && cand == DEF && !(busreq[DEF] && order[k] != DEF && 0)) begin
        cand = order[k];
        break;
      end
      m_data    = m_owner;
      m_owner   = m_grant;
      m_lock    = lock[m_grant];
      m_in_lock = lock[m_grant];
      if (!frozen) m_grant = cand;
    end
    m_rem = nx_rem;
  endtask

  function automatic logic [8:0] exp_vec();
    logic [3:0] g;
    g = 4'b0001 << m_grant;
    return {g, 2'(m_owner), 2'(m_data), m_lock};
  endfunction

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    busreq = 4'd0; lock = 4'd0; trans = 2'd0; burst = 3'd0; ready = 1'b1; resp = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (obs !== 9'b0001_00_00_0) $display("FAIL reset_values: got %h expected %h", obs, 9'b0001_00_00_0);
    else n_pass++;
    for (int k = 0; k < 10; k++) begin
      tick();
      n_checks++;
      if (obs !== 9'b0001_00_00_0) $display("FAIL reset_idle_hold: cycle %0d got %h expected %h", k, obs, 9'b0001_00_00_0);
      else n_pass++;
      n_checks++;
      if (obs !== exp_vec()) $display("FAIL reset_model: got %h expected %h", obs, exp_vec());
      else n_pass++;
    end
  endtask

  task automatic test_alternate();
    logic [3:0] eg;
    logic [1:0] eo, ed;
    do_reset();
    busreq = 4'b0110; trans = 2'd2; burst = 3'd0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      eg = ((k % 2) != 0) ? 4'b0010 : 4'b0100;
      eo = ((k % 2) != 0) ? 2'd2 : 2'd1;
      ed = ((k % 2) != 0) ? 2'd1 : 2'd2;
      n_checks++;
      if (grant !== eg) $display("FAIL alt_grant: edge %0d got %b expected %b", k, grant, eg);
      else n_pass++;
      if (k >= 2) begin
        n_checks++;
        if (master !== eo) $display("FAIL alt_master: edge %0d got %0d expected %0d", k, master, eo);
        else n_pass++;
      end
      if (k >= 3) begin
        n_checks++;
        if (data !== ed) $display("FAIL alt_data: edge %0d got %0d expected %0d", k, data, ed);
        else n_pass++;
      end
      n_checks++;
      if (obs !== exp_vec()) $display("FAIL alt_model: got %h expected %h", obs, exp_vec());
      else n_pass++;
    end
  endtask

  task automatic test_incr4();
    logic [1:0] t_tab [3] = '{2'd2, 2'd3, 2'd3};
    logic [3:0] g_tab [3] = '{4'b0010, 4'b0010, 4'b1000};
    do_reset();
    busreq = 4'b0010;
    tick(); tick();
    busreq = 4'b1010; burst = 3'd3;
    for (int k = 0; k < 3; k++) begin
      trans = t_tab[k];
      tick();
      n_checks++;
      if ({grant, master} !== {g_tab[k], 2'd1}) $display("FAIL incr4_beat: step %0d got %b/%0d expected %b/1", k, grant, master, g_tab[k]);
      else n_pass++;
      n_checks++;
      if (obs !== exp_vec()) $display("FAIL incr4_model: got %h expected %h", obs, exp_vec());
      else n_pass++;
    end
    busreq = 4'b1000; trans = 2'd3;
    tick();
    n_checks++;
    if ({grant, master, data} !== {4'b1000, 2'd3, 2'd1}) $display("FAIL incr4_handover: got %h expected %h", {grant, master, data}, {4'b1000, 2'd3, 2'd1});
    else n_pass++;
    trans = 2'd0; busreq = 4'd0;
  endtask

  task automatic test_incr4_stall();
    logic [1:0] t_tab [6] = '{2'd2, 2'd3, 2'd3, 2'd3, 2'd1, 2'd3};
    logic       r_tab [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [3:0] g_tab [6] = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b1000};
    do_reset();
    busreq = 4'b0010;
    tick(); tick();
    busreq = 4'b1010; burst = 3'd3;
    for (int k = 0; k < 6; k++) begin
      trans = t_tab[k]; ready = r_tab[k];
      tick();
      n_checks++;
      if ({grant, master} !== {g_tab[k], 2'd1}) $display("FAIL stall_beat: step %0d got %b/%0d expected %b/1", k, grant, master, g_tab[k]);
      else n_pass++;
      n_checks++;
      if (obs !== exp_vec()) $display("FAIL stall_model: got %h expected %h", obs, exp_vec());
      else n_pass++;
    end
    busreq = 4'b1000; trans = 2'd3; ready = 1'b1;
    tick();
    n_checks++;
    if (master !== 2'd3) $display("FAIL stall_handover: got %0d expected 3", master);
    else n_pass++;
    trans = 2'd0; busreq = 4'd0;
  endtask

  task automatic test_lock();
    logic [3:0] g_tab [5] = '{4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0001};
    logic       l_tab [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    do_reset();
    busreq = 4'b0100; lock = 4'b0100;
    for (int k = 0; k < 5; k++) begin
      if (k == 1) begin busreq = 4'b0101; trans = 2'd2; burst = 3'd0; end
      if (k == 3) begin busreq = 4'b0001; lock = 4'b0000; trans = 2'd0; end
      tick();
      n_checks++;
      if ({grant, mastlock} !== {g_tab[k], l_tab[k]}) $display("FAIL lock_seq: edge %0d got %b/%b expected %b/%b", k, grant, mastlock, g_tab[k], l_tab[k]);
      else n_pass++;
      if (k >= 1 && k <= 4) begin
        n_checks++;
        if (master !== 2'd2) $display("FAIL lock_owner: edge %0d got %0d expected 2", k, master);
        else n_pass++;
      end
      n_checks++;
      if (obs !== exp_vec()) $display("FAIL lock_model: got %h expected %h", obs, exp_vec());
      else n_pass++;
    end
    tick();
    n_checks++;
    if (master !== 2'd0) $display("FAIL lock_release_owner: got %0d expected 0", master);
    else n_pass++;
  endtask

  task automatic test_error_reset();
    do_reset();
    busreq = 4'b0010;
    tick(); tick();
    busreq = 4'b0110; trans = 2'd2; burst = 3'd5;
    tick();
    trans = 2'd3;
    tick();
    resp = 1'b1; ready = 1'b0;
    tick();
    n_checks++;
    if (grant !== 4'b0010) $display("FAIL err_first_cycle: got %b expected 0010", grant);
    else n_pass++;
    ready = 1'b1; trans = 2'd0;
    tick();
    n_checks++;
    if (grant !== 4'b0100) $display("FAIL err_rearb: got %b expected 0100", grant);
    else n_pass++;
    n_checks++;
    if (obs !== exp_vec()) $display("FAIL err_model: got %h expected %h", obs, exp_vec());
    else n_pass++;
    resp = 1'b0; busreq = 4'b0100;
    tick();
    trans = 2'd2; burst = 3'd5;
    tick();
    trans = 2'd3;
    tick();
    n_checks++;
    if ({grant, master} !== {4'b0100, 2'd2}) $display("FAIL err_burst2: got %b/%0d expected 0100/2", grant, master);
    else n_pass++;
    rst = 1'b1;
    tick();
    n_checks++;
    if (obs !== 9'b0001_00_00_0) $display("FAIL midburst_reset: got %h expected %h", obs, 9'b0001_00_00_0);
    else n_pass++;
    rst = 1'b0; busreq = 4'd0; trans = 2'd0;
    tick();
    n_checks++;
    if (obs !== 9'b0001_00_00_0) $display("FAIL post_reset_idle: got %h expected %h", obs, 9'b0001_00_00_0);
    else n_pass++;
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 600; k++) begin
      busreq = 4'($urandom());
      if ($urandom_range(0, 5) == 0)
        lock = ($urandom_range(0, 2) == 0) ? 4'(4'b0001 << $urandom_range(0, 3)) : 4'b0000;
      trans = 2'($urandom());
      burst = 3'($urandom());
      ready = ($urandom_range(0, 3) != 0);
      resp  = ($urandom_range(0, 9) == 0);
      rst   = ($urandom_range(0, 63) == 0);
      tick();
      n_checks++;
      if (obs !== exp_vec()) $display("FAIL rand_model: cycle %0d got %h expected %h", k, obs, exp_vec());
      else n_pass++;
      n_checks++;
      if (!$onehot(grant)) $display("FAIL rand_onehot: cycle %0d got %b expected one-hot", k, grant);
      else n_pass++;
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; busreq = 4'd0; lock = 4'd0; trans = 2'd0; burst = 3'd0; ready = 1'b1; resp = 1'b0;
    test_reset();
    test_alternate();
    test_incr4();
    test_incr4_stall();
    test_lock();
    test_error_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
